// File: rtl/inst_fetcher.sv
// Instruction fetcher: issues 64-bit aligned reads and buffers {pc, inst} pairs for the core.
// Latency: a response shows on if_valid the cycle after mem_rvalid; requests are at least 2 cycles apart.
// Backpressure: one read outstanding at most; no request while the buffer is full; redirect flushes everything.
module inst_fetcher #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4      // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);
    localparam int XLEN           = 64;
    localparam int ILEN           = 32;
    localparam int MEM_ADDR_WIDTH = 16;
    localparam int PW             = $clog2(FIFO_DEPTH);
    localparam int CW             = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // may issue a request
        S_WAIT = 2'd1,   // request outstanding, response wanted
        S_DROP = 2'd2    // request outstanding, response to be discarded
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;

    fetch_entry_t    buf_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            buf_full;
    logic            buf_empty;

    logic            req_fire;
    logic            rsp_take;
    logic            if_pop;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    head_entry;

    assign buf_full  = (count == FULL_CNT);
    assign buf_empty = (count == '0);

    // The 64-bit word holds two instructions; req_pc[2] picks the half.
    assign rsp_entry.pc   = req_pc;
    assign rsp_entry.inst = req_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    assign head_entry = buf_mem[rd_ptr];
    assign if_pc      = head_entry.pc;
    assign if_inst    = head_entry.inst;

    // Next state, memory request and core-side valid; outputs held at zero while in reset
    always_comb begin
        state_nxt = state;
        mem_valid = 1'b0;
        mem_addr  = '0;
        if_valid  = 1'b0;
        if (!rst) begin
            mem_valid = (state == S_REQ) && !buf_full;
            mem_addr  = {fetch_pc[MEM_ADDR_WIDTH-1:3], 3'b000};
            if_valid  = !buf_empty && !redirect_valid;
        end
        req_fire = mem_valid && mem_ready;
        rsp_take = (state == S_WAIT) && mem_rvalid && !redirect_valid;
        if_pop   = if_valid && if_ready;

        unique case (state)
            S_REQ: begin
                // A request committed in a redirect cycle is already stale.
                if (req_fire) state_nxt = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid)          state_nxt = S_REQ;
                else if (redirect_valid) state_nxt = S_DROP;
            end
            S_DROP: begin
                if (mem_rvalid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    // Fetch PC and the PC of the request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~64'h3;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 64'd4;
            req_pc   <= fetch_pc;
        end
    end

    // Buffer storage; cleared on reset so the head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) buf_mem[i] <= '0;
        end else if (rsp_take) begin
            buf_mem[wr_ptr] <= rsp_entry;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer and wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rsp_take) wr_ptr <= wr_ptr + 1'b1;
            if (if_pop)   rd_ptr <= rd_ptr + 1'b1;
            if (rsp_take && !if_pop)      count <= count + 1'b1;
            else if (!rsp_take && if_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;
    localparam logic [63:0] RESET_PC   = 64'h0;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    inst_fetcher #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: every 4-byte slot holds a distinct instruction; slots 0/4 hold a known pair.
    function automatic logic [31:0] inst_at(input logic [15:0] a);
        if (a == 16'h0000) return 32'h00100013;
        if (a == 16'h0004) return 32'h00500093;
        return {a ^ 16'hC3A5, ~a};
    endfunction

    function automatic logic [63:0] word_at(input logic [15:0] w);
        return {inst_at(w + 16'd4), inst_at(w)};
    endfunction

    // Expected instruction stream: consecutive PCs from the latest restart point.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    task automatic restart_stream(input logic [63:0] start);
        logic [63:0] p;
        exp_t e;
        exp_q.delete();
        p = start & ~64'h3;
        for (int i = 0; i < 64; i++) begin
            e.pc   = p;
            e.inst = inst_at({p[15:2], 2'b00});
            exp_q.push_back(e);
            p = p + 64'd4;
        end
    endtask

    // Memory model state
    logic [15:0] pend_addr[$];
    int          pend_wait[$];
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;
    bit          ready_low = 1'b0;
    int          hs_cnt    = 0;
    int          resp_cnt  = 0;
    logic [15:0] last_hs_addr = '0;

    // Memory model: accept requests (sampled mid-cycle)
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend_addr.delete();
            pend_wait.delete();
        end else if (mem_valid && mem_ready) begin
            check("req_align", {61'd0, mem_addr[2:0]}, 64'd0);
            check("one_outstanding", pend_addr.size(), 0);
            pend_addr.push_back(mem_addr);
            pend_wait.push_back(int'($urandom_range(lat_min, lat_max)));
            last_hs_addr = mem_addr;
            hs_cnt++;
        end
    end

    // Memory model: drive ready and responses just after the edge
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            mem_ready  = !ready_low && ($urandom_range(0, 99) < ready_pct);
            if (!rst && pend_addr.size() > 0) begin
                if (pend_wait[0] <= 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word_at(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_wait.pop_front());
                    resp_cnt++;
                end else begin
                    pend_wait[0] = pend_wait[0] - 1;
                end
            end
        end
    end

    // Monitor: compare every consumed instruction against the expected stream
    int          pops = 0;
    logic [63:0] last_pop_pc = '0;
    logic [31:0] last_pop_inst = '0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (redirect_valid) check("if_valid_during_redirect", if_valid, 0);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got pc %h with nothing expected", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_inst", if_inst, e.inst);
                end
                last_pop_pc   = if_pc;
                last_pop_inst = if_inst;
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        restart_stream(RESET_PC);
        repeat (hold) tick();
        hs_cnt = 0;
        resp_cnt = 0;
        pops = 0;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h;
        int p0;
        int since;
        logic [63:0] tgt;
        logic [63:0] w;

        rst = 1'b1;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset values
        #3;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_inst", if_inst, 0);

        // First fetch pair from word 0, consumed immediately
        if_ready = 1'b1;
        do_reset(3);
        #1;
        check("first_cycle_mem_valid", mem_valid, 1);
        check("first_cycle_mem_addr", mem_addr, 0);
        for (int i = 0; i < 40 && pops < 2; i++) tick();
        check("pair_pops", pops, 2);
        check("pair_second_pc", last_pop_pc, 64'h4);
        check("pair_second_inst", last_pop_inst, 64'h00500093);

        // Core stalled: requests stop at buffer depth, one pop buys one request
        if_ready = 1'b0;
        do_reset(2);
        repeat (30) tick();
        check("stall_req_count", hs_cnt, FIFO_DEPTH);
        @(negedge clk);
        check("stall_mem_valid", mem_valid, 0);
        tick();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        repeat (20) tick();
        check("stall_pulse_req_count", hs_cnt, FIFO_DEPTH + 1);
        check("stall_pulse_pops", pops, 1);

        // Redirect while a request is outstanding; its response arrives later and is dropped
        lat_min = 3; lat_max = 3;
        if_ready = 1'b1;
        do_reset(2);
        for (int i = 0; i < 60 && hs_cnt < 3; i++) tick();
        h = hs_cnt;
        for (int i = 0; i < 20 && hs_cnt == h; i++) tick();
        check("wait_redirect_reached", (hs_cnt > h) ? 1 : 0, 1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h1000;
        restart_stream(64'h1000);
        h = hs_cnt;
        p0 = pops;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && hs_cnt == h; i++) tick();
        check("wait_redirect_next_addr", last_hs_addr, 64'h1000);
        for (int i = 0; i < 20 && pops == p0; i++) tick();
        check("wait_redirect_first_pc", last_pop_pc, 64'h1000);

        // Redirect to an unaligned target with two buffered entries and if_ready high
        lat_min = 1; lat_max = 1;
        if_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 30 && resp_cnt < 2; i++) tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2006;
        if_ready = 1'b1;
        restart_stream(64'h2004);
        #1;
        check("redir_if_valid", if_valid, 0);
        p0 = pops;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && pops == p0; i++) tick();
        w = word_at(16'h2000);
        check("redir_first_pc", last_pop_pc, 64'h2004);
        check("redir_first_inst", last_pop_inst, {32'h0, w[63:32]});

        // Memory not ready: request held stable and fetch PC does not move
        ready_low = 1'b1;
        if_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_mem_valid", mem_valid, 1);
            check("hold_mem_addr", mem_addr, 0);
        end
        ready_low = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 20 && pops < 1; i++) tick();
        check("hold_first_pc", last_pop_pc, RESET_PC);

        // Reset in the middle of a request with three buffered entries
        lat_min = 2; lat_max = 2;
        if_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 40 && resp_cnt < 3; i++) tick();
        for (int i = 0; i < 20 && hs_cnt < 4; i++) tick();
        check("midrst_reached", hs_cnt, 4);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_if_valid", if_valid, 0);
        check("midrst_mem_valid", mem_valid, 0);
        check("midrst_if_pc", if_pc, 0);
        do_reset(2);
        for (int i = 0; i < 10 && hs_cnt < 1; i++) tick();
        check("midrst_restart_addr", last_hs_addr, 0);
        if_ready = 1'b1;
        for (int i = 0; i < 20 && pops < 1; i++) tick();
        check("midrst_first_pc", last_pop_pc, RESET_PC);

        // Randomized traffic with redirects, including a target that wraps the 64-bit PC
        ready_pct = 70;
        lat_min = 1; lat_max = 4;
        do_reset(2);
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            if (since >= 90 || $urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 2))
                    0:       tgt = {$urandom, $urandom};
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                    default: tgt = 64'($urandom_range(0, 65535));
                endcase
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                restart_stream(tgt);
                since = 0;
            end else begin
                redirect_valid = 1'b0;
                since++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        check("random_progress", (pops >= 100) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 0, which is the 64-bit fetch address loaded on reset.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4, which is the instruction buffer depth and must be a power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 mem_valid  out  1  memory read request valid.
REQ-006 mem_ready  in  1  memory accepts the request this cycle.
REQ-007 mem_addr  out  MEM_ADDR_WIDTH (16)  byte address of a 64-bit aligned word, bits [2:0] = 0.
REQ-008 mem_rvalid  in  1  read response valid.
REQ-009 mem_rdata  in  MEM_DATA_WIDTH (64)  read response data.
REQ-010 if_valid  out  1  instruction available to the core.
REQ-011 if_ready  in  1  core consumes the instruction.
REQ-012 if_pc  out  XLEN (64)  PC of the head instruction.
REQ-013 if_inst  out  ILEN (32)  head instruction.
REQ-014 redirect_valid  in  1  flush and restart fetch (jump, branch, trap to MTVEC, return to MEPC).
REQ-015 redirect_pc  in  XLEN  new fetch PC; bits [1:0] are treated as zero.

Function
REQ-016 The block SHALL track fetch_pc (64-bit), req_pc (PC of the outstanding request), a FIFO of {pc, inst} entries, count (0..FIFO_DEPTH), and state in {S_REQ, S_WAIT, S_DROP}.
REQ-017 In S_REQ, mem_valid SHALL be asserted when count < FIFO_DEPTH, with mem_addr = {fetch_pc[15:3], 3'b000}; it SHALL be deasserted otherwise.
REQ-018 In S_WAIT and S_DROP, mem_valid SHALL be 0, so at most one request is ever outstanding.
REQ-019 On a request handshake (mem_valid && mem_ready) without redirect, the block SHALL set req_pc = fetch_pc, advance fetch_pc by 4 (64-bit wrap), and move to S_WAIT.
REQ-020 On mem_rvalid in S_WAIT without redirect, the block SHALL enqueue {req_pc, req_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0]}, increment count, and move to S_REQ.
REQ-021 The enqueued entry SHALL be visible on if_valid the cycle after mem_rvalid; the minimum request-to-request spacing is 2 cycles.
REQ-022 if_valid SHALL equal (count != 0) && !redirect_valid.
REQ-023 if_pc and if_inst SHALL reflect the FIFO head; their value is don't-care while if_valid = 0, except at reset.
REQ-024 A dequeue SHALL occur on if_valid && if_ready.
REQ-025 A simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 When count = FIFO_DEPTH, no request SHALL be issued, and no overflow is possible.
REQ-028 A dequeue on an empty FIFO SHALL be impossible because if_valid = 0.
REQ-029 On redirect_valid, regardless of state, the block SHALL empty the FIFO (count = 0, pointers reset), set fetch_pc = {redirect_pc[63:2], 2'b00}, and ignore if_ready that cycle.
REQ-030 A redirect in S_REQ with a request handshake in the same cycle SHALL go to S_DROP; without a handshake it SHALL stay in S_REQ.
REQ-031 A redirect in S_WAIT without mem_rvalid SHALL go to S_DROP.
REQ-032 A redirect in S_WAIT with mem_rvalid SHALL discard the data and go to S_REQ.
REQ-033 In S_DROP, mem_rvalid SHALL discard the data and go to S_REQ.
REQ-034 A redirect in S_DROP SHALL update fetch_pc and stay in S_DROP, or go to S_REQ if mem_rvalid is present in the same cycle.
REQ-035 mem_valid and mem_addr MAY change in a redirect cycle without a prior handshake, because a request is committed only on handshake.
REQ-036 mem_rvalid in S_REQ SHALL be ignored.

Reset
REQ-037 While rst = 1, asynchronously, the block SHALL force state = S_REQ, fetch_pc = RESET_PC, req_pc = 0, count = 0 and pointers = 0.
REQ-038 While rst = 1, outputs SHALL be mem_valid = 0, mem_addr = 0, if_valid = 0, if_pc = 0 and if_inst = 0.
REQ-039 FIFO storage SHALL be reset to 0.
REQ-040 Reset asserted mid-transaction SHALL abandon any outstanding request; the memory model is reset alongside.
REQ-041 The first mem_valid SHALL assert in the first cycle after rst deasserts.

Verification
REQ-042 Reset with RESET_PC = 0 and a memory that is always ready with 1-cycle latency, word 0 = 0x00500093_00100013 -> if_pc = 0 / if_inst = 0x00100013, then if_pc = 4 / if_inst = 0x00500093.
REQ-043 if_ready held 0 with FIFO_DEPTH = 4 -> exactly 4 requests issued, then mem_valid stays 0; one if_ready pulse -> exactly one further request.
REQ-044 Redirect to 0x1000 while in S_WAIT; a stale response arrives 3 cycles later -> the stale data is never enqueued; the next mem_addr = 0x1000; the first if_pc = 0x1000.
REQ-045 Redirect to 0x2006 together with if_ready=1 while count = 2 -> if_valid = 0 that cycle, FIFO emptied, next if_pc = 0x2004 taken from mem_rdata[63:32].
REQ-046 mem_ready held 0 for 5 cycles -> mem_valid and mem_addr stay stable, fetch_pc does not advance.
REQ-047 rst asserted in S_WAIT with count = 3 -> if_valid = 0 immediately; after release, fetch restarts at RESET_PC.
